jtopl_wrq: RTL and testbench

- Host-side write queue and pacer that sits directly upstream of the OPL2 core.
- Buffers (register, value) write pairs from a fast host bus.
- Replays each pair to the core's addr/din/cs_n/wr_n pins as an address write, then a data write.
- Enforces the chip's post-address and post-data wait times, counted in cen ticks, so host software needs no busy-wait loops.

---
 rtl/jtopl_wrq_pkg.sv | 29 ++
 rtl/jtopl_wrq_fifo.sv | 65 ++++++
 rtl/jtopl_wrq.sv | 196 +++++++++++++++++++
 tb/tb_jtopl_wrq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_wrq_pkg.sv
// Shared types and constants for the jtopl_wrq host write queue and pacer.
// FIFO entry layout: register number in [15:8], value in [7:0].
package jtopl_wrq_pkg;

    // Default waits in cen ticks, derived from the 3.58 MHz OPL2 timing.
    localparam int ADDR_WAIT_DEF = 12;
    localparam int DATA_WAIT_DEF = 84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASTB,
        ST_AWAIT,
        ST_DSTB,
        ST_DWAIT
    } wrq_state_e;

    typedef struct packed {
        logic [7:0] rnum;
        logic [7:0] val;
    } wrq_entry_t;

    // Counter width able to hold max(a, d) - 1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int d);
        int m;
        m = (a > d) ? a : d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/jtopl_wrq_fifo.sv
// Single-clock synchronous FIFO of (register, value) pairs with synchronous flush.
// Pushes while full and pops while empty are ignored.
module jtopl_wrq_fifo
    import jtopl_wrq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  wrq_entry_t din,
    output wrq_entry_t dout,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    wrq_entry_t            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the flushed pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/jtopl_wrq.sv
// Host write queue and pacer feeding the OPL2 core bus with address/data strobes.
// Optional macro JTOPL_WRQ_SKIPADDR_EN skips the address phase on a repeated register.
module jtopl_wrq
    import jtopl_wrq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_WAIT  = ADDR_WAIT_DEF,
    parameter int DATA_WAIT  = DATA_WAIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr_en,
    input  logic [7:0] wr_reg,
    input  logic [7:0] wr_val,
    output logic       full,
    output logic       idle,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       opl_addr,
    output logic [7:0] opl_din,
    output logic       opl_cs_n,
    output logic       opl_wr_n
);

    localparam int CNT_W = cnt_width(ADDR_WAIT, DATA_WAIT);
    localparam logic [CNT_W-1:0] AW_LOAD = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DW_LOAD = CNT_W'(DATA_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (ADDR_WAIT < 1 || DATA_WAIT < 1) begin : g_bad_wait
        $error("jtopl_wrq: ADDR_WAIT and DATA_WAIT must both be at least 1");
    end

    wrq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       val_q, val_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic             addr_q, addr_d;
    logic [7:0]       din_q, din_d;
    logic             ovf_q, ovf_d;

    logic       fifo_full, fifo_empty;
    wrq_entry_t fifo_dout, push_data;
    logic       push, pop, skip_hit;

    assign push_data = {wr_reg, wr_val};
    assign push      = wr_en && !fifo_full;

    jtopl_wrq_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (push_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

`ifdef JTOPL_WRQ_SKIPADDR_EN
    logic [7:0] last_reg_q, last_reg_d;
    logic       last_vld_q, last_vld_d;

    assign skip_hit = last_vld_q && (fifo_dout.rnum == last_reg_q);

    always_comb begin
        last_reg_d = last_reg_q;
        last_vld_d = last_vld_q;
        if (cen && state_q == ST_ASTB) begin
            last_reg_d = reg_q;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_reg_q <= last_reg_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign skip_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        val_d   = val_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        addr_d  = addr_q;
        din_d   = din_q;
        pop     = 1'b0;

        // Set wins over clear; a push while full is dropped even if a pop coincides.
        ovf_d = (wr_en && fifo_full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        if (cen) begin
            case (state_q)
                ST_IDLE: pop = !fifo_empty;
                ST_ASTB: begin
                    state_d = ST_AWAIT;
                    cnt_d   = AW_LOAD;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    din_d   = reg_q;
                end
                ST_AWAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DSTB;
                        cs_n_d  = 1'b0;
                        wr_n_d  = 1'b0;
                        addr_d  = 1'b1;
                        din_d   = val_q;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DSTB: begin
                    state_d = ST_DWAIT;
                    cnt_d   = DW_LOAD;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end
                ST_DWAIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        pop     = !fifo_empty;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Outputs are registered, so the first strobe of a pair is set up on the pop edge.
            if (pop) begin
                reg_d  = fifo_dout.rnum;
                val_d  = fifo_dout.val;
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                if (skip_hit) begin
                    state_d = ST_DSTB;
                    addr_d  = 1'b1;
                    din_d   = fifo_dout.val;
                end else begin
                    state_d = ST_ASTB;
                    addr_d  = 1'b0;
                    din_d   = fifo_dout.rnum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= 1'b0;
            din_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full     = fifo_full;
    assign idle     = fifo_empty && (state_q == ST_IDLE);
    assign overflow = ovf_q;
    assign opl_addr = addr_q;
    assign opl_din  = din_q;
    assign opl_cs_n = cs_n_q;
    assign opl_wr_n = wr_n_q;

endmodule

// File: tb/tb_jtopl_wrq.sv
// Self-checking bench for jtopl_wrq: strobe timing model, overflow table, reset and cen corner cases.
module tb_jtopl_wrq;

    localparam int AW = 12;
    localparam int DW = 84;
`ifdef JTOPL_WRQ_SKIPADDR_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cen, wr_en, ovf_clr;
    logic [7:0] wr_reg, wr_val;
    logic       full, idle, overflow, opl_addr, opl_cs_n, opl_wr_n;
    logic [7:0] opl_din;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cen_div = 1;

    typedef struct { int cyc; logic addr; logic [7:0] din; int len; } ev_t;
    typedef struct { logic [7:0] r; logic [7:0] v; int cyc; } push_t;
    typedef struct { logic we; logic [7:0] r; logic [7:0] v; logic clr; logic exp_full; logic exp_ovf; } vec_t;

    ev_t   evq[$];
    ev_t   expq[$];
    push_t pq[$];
    ev_t   cur;
    bit    in_stb = 1'b0;

    jtopl_wrq #(.DEPTH_LOG2(4), .ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .wr_en(wr_en), .wr_reg(wr_reg), .wr_val(wr_val),
        .full(full), .idle(idle), .overflow(overflow), .ovf_clr(ovf_clr),
        .opl_addr(opl_addr), .opl_din(opl_din), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cen_div == 0) cen = 1'b0;
            else if (cen_div == 1) cen = 1'b1;
            else cen = ((cyc % cen_div) == 0);
        end
    end

    // Strobe monitor: one record per low pulse of cs_n&wr_n, with start cycle and length.
    always @(negedge clk) begin
        if (!opl_cs_n && !opl_wr_n) begin
            if (!in_stb) begin
                in_stb   = 1'b1;
                cur.cyc  = cyc;
                cur.addr = opl_addr;
                cur.din  = opl_din;
                cur.len  = 1;
            end else begin
                cur.len++;
            end
        end else if (in_stb) begin
            in_stb = 1'b0;
            evq.push_back(cur);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        evq.delete();
        pq.delete();
        tick(1);
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] v);
        wr_reg = r;
        wr_val = v;
        wr_en  = 1'b1;
        pq.push_back('{r: r, v: v, cyc: cyc});
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_events(input string name, input int n, input int budget);
        int k = 0;
        while (evq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk({name, "_evcount"}, evq.size(), n);
    endtask

    // Reference: each pair's first strobe lands at max(push+2, previous data strobe + DW + 1).
    function automatic void build_exp();
        int   d_prev = 0;
        bit   have_prev = 1'b0;
        bit   last_vld = 1'b0;
        logic [7:0] last_reg = '0;
        int   t, d;
        expq.delete();
        foreach (pq[i]) begin
            t = pq[i].cyc + 2;
            if (have_prev && t < d_prev + DW + 1) t = d_prev + DW + 1;
            if (SKIP && last_vld && pq[i].r == last_reg) begin
                d = t;
            end else begin
                expq.push_back('{cyc: t, addr: 1'b0, din: pq[i].r, len: 1});
                d = t + AW + 1;
                last_vld = 1'b1;
                last_reg = pq[i].r;
            end
            expq.push_back('{cyc: d, addr: 1'b1, din: pq[i].v, len: 1});
            d_prev = d;
            have_prev = 1'b1;
        end
    endfunction

    task automatic model_check(input string name);
        int n;
        build_exp();
        wait_events(name, expq.size(), 20000);
        tick(120);
        chk({name, "_no_extra"}, evq.size(), expq.size());
        chk({name, "_idle_end"}, idle, 1);
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ev%0d_cyc", name, i), evq[i].cyc, expq[i].cyc);
            chk($sformatf("%s_ev%0d_addr", name, i), evq[i].addr, expq[i].addr);
            chk($sformatf("%s_ev%0d_din", name, i), evq[i].din, expq[i].din);
            chk($sformatf("%s_ev%0d_len", name, i), evq[i].len, expq[i].len);
        end
    endtask

    vec_t vt[20];

    initial begin
        int n0;
        int d0;
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{we: 1'b1, r: 8'(8'h40 + i), v: 8'(8'h80 + i), clr: 1'b0, exp_full: (i == 15), exp_ovf: 1'b0};
        end
        vt[16] = '{we: 1'b1, r: 8'hEE, v: 8'hEE, clr: 1'b0, exp_full: 1'b1, exp_ovf: 1'b1};
        vt[17] = '{we: 1'b1, r: 8'hEF, v: 8'hEF, clr: 1'b1, exp_full: 1'b1, exp_ovf: 1'b1};
        vt[18] = '{we: 1'b0, r: 8'h00, v: 8'h00, clr: 1'b1, exp_full: 1'b1, exp_ovf: 1'b0};
        vt[19] = '{we: 1'b0, r: 8'h00, v: 8'h00, clr: 1'b0, exp_full: 1'b1, exp_ovf: 1'b0};

        rst = 1'b1; cen = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; wr_reg = '0; wr_val = '0;
        tick(3);
        chk("rst_cs_n", opl_cs_n, 1);
        chk("rst_wr_n", opl_wr_n, 1);
        chk("rst_addr", opl_addr, 0);
        chk("rst_din", opl_din, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_full", full, 0);
        chk("rst_idle", idle, 1);
        rst = 1'b0;
        tick(2);

        // Single pair: strobe at push+2, data 13 later, idle 85 after the data strobe.
        do_reset();
        n0 = cyc;
        push(8'h20, 8'h01);
        wait_cyc(n0 + 2);
        chk("single_astb_cs", opl_cs_n, 0);
        chk("single_astb_din", opl_din, 8'h20);
        d0 = n0 + 2 + AW + 1;
        wait_cyc(d0 + DW);
        chk("single_idle_early", idle, 0);
        chk("single_din_hold", opl_din, 8'h01);
        tick(1);
        chk("single_idle_late", idle, 1);
        model_check("single");

        do_reset();
        push(8'hB0, 8'h11);
        push(8'hB1, 8'h22);
        push(8'hB2, 8'h33);
        model_check("b2b");

        do_reset();
        push(8'hA0, 8'h10);
        push(8'hA0, 8'h20);
        model_check("skipaddr");

        do_reset();
        begin
            int gap;
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 2))
                    0: wr_reg = 8'h20;
                    1: wr_reg = 8'h21;
                    default: wr_reg = 8'hB0;
                endcase
                push(wr_reg, 8'($urandom_range(0, 255)));
                gap = $urandom_range(0, 120);
                tick(gap);
            end
        end
        model_check("random");

        // cen every 4th clk: strobes 4 clks wide, 13 ticks apart.
        do_reset();
        cen_div = 4;
        push(8'h33, 8'h44);
        wait_events("cen4", 2, 400);
        if (evq.size() >= 2) begin
            chk("cen4_alen", evq[0].len, 4);
            chk("cen4_dlen", evq[1].len, 4);
            chk("cen4_spacing", evq[1].cyc - evq[0].cyc, 4 * (AW + 1));
            chk("cen4_ddin", evq[1].din, 8'h44);
        end
        tick(4 * (DW + 2));
        chk("cen4_idle", idle, 1);
        cen_div = 1;

        // Stalled FSM: 16 pushes fill, extras dropped, overflow sticky with set-over-clear.
        do_reset();
        cen_div = 0;
        cen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr_en = vt[i].we; wr_reg = vt[i].r; wr_val = vt[i].v; ovf_clr = vt[i].clr;
            tick(1);
            chk($sformatf("ovf_vec%0d_full", i), full, vt[i].exp_full);
            chk($sformatf("ovf_vec%0d_ovf", i), overflow, vt[i].exp_ovf);
        end
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("ovf_stall_nostrobe", evq.size(), 0);
        cen_div = 1;
        wait_events("ovf_replay", 32, 3000);
        tick(120);
        chk("ovf_replay_total", evq.size(), 32);
        for (int i = 0; i < 16 && 2 * i + 1 < evq.size(); i++) begin
            chk($sformatf("ovf_replay%0d_reg", i), evq[2 * i].din, 8'h40 + i);
            chk($sformatf("ovf_replay%0d_val", i), evq[2 * i + 1].din, 8'h80 + i);
        end

        // Reset during AWAIT discards the in-flight and queued pairs.
        do_reset();
        push(8'h01, 8'h02);
        push(8'h03, 8'h04);
        push(8'h05, 8'h06);
        wait_events("rstmid_astb", 1, 50);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstmid_cs_n", opl_cs_n, 1);
        chk("rstmid_wr_n", opl_wr_n, 1);
        chk("rstmid_idle", idle, 1);
        tick(300);
        chk("rstmid_no_more", evq.size(), 1);
        chk("rstmid_idle_end", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
